// File: rtl/uib_pkg.sv
// Shared UIB definitions: lane-mode encodings, DMA FSM state type and word stride.
package uib_pkg;

    localparam logic [1:0] UIB_MODE_BYTE = 2'b00;
    localparam logic [1:0] UIB_MODE_HALF = 2'b01;
    localparam logic [1:0] UIB_MODE_WORD = 2'b10;

    localparam int unsigned UIB_WORD_STRIDE = 4;

    typedef enum logic [2:0] {
        DMA_IDLE = 3'd0,
        DMA_RD   = 3'd1,
        DMA_CAP  = 3'd2,
        DMA_WR   = 3'd3,
        DMA_FIN  = 3'd4
    } dma_state_t;

endpackage

// File: rtl/uib_dma.sv
// UIB master word-copy DMA: read / capture / write per word, done pulse on completion.
// Optional macro UIB_DMA_FILL_EN adds a 1-word-per-cycle pattern fill mode.
module uib_dma
    import uib_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  src_addr,
    input  logic [XLEN-1:0]  dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
`ifdef UIB_DMA_FILL_EN
    input  logic             fill,
    input  logic [XLEN-1:0]  fill_pattern,
`endif
    output logic             busy,
    output logic             done,
    output logic             bus_req,
    output logic             bus_wen,
    output logic [XLEN-1:0]  bus_addr,
    output logic [1:0]       bus_mode,
    output logic [XLEN-1:0]  bus_dat_o,
    input  logic [XLEN-1:0]  bus_dat_i
);

    localparam logic [XLEN-1:0]  STRIDE = XLEN'(UIB_WORD_STRIDE);
    localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);

    dma_state_t       state_q, state_d;
    logic [XLEN-1:0]  src_q, src_d;
    logic [XLEN-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             done_q, done_d;
`ifdef UIB_DMA_FILL_EN
    logic             fill_q, fill_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef UIB_DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef UIB_DMA_FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
`ifdef UIB_DMA_FILL_EN
        fill_d    = fill_q;
`endif
        bus_req   = 1'b0;
        bus_wen   = 1'b0;
        bus_addr  = '0;
        bus_dat_o = '0;

        unique case (state_q)
            DMA_IDLE: begin
                // start outranks abort here: abort only acts on an active transfer
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    cnt_d   = len;
                    state_d = DMA_RD;
`ifdef UIB_DMA_FILL_EN
                    fill_d = fill;
                    if (fill) begin
                        data_d  = fill_pattern;
                        state_d = DMA_WR;
                    end
`endif
                    if (len == '0) begin
                        state_d = DMA_FIN;
                    end
                end
            end
            DMA_RD: begin
                bus_req  = 1'b1;
                bus_addr = src_q;
                state_d  = abort ? DMA_IDLE : DMA_CAP;
            end
            DMA_CAP: begin
                data_d  = bus_dat_i;
                state_d = abort ? DMA_IDLE : DMA_WR;
            end
            DMA_WR: begin
                // The write strobe is already on the bus this cycle, so abort lets it finish.
                bus_req   = 1'b1;
                bus_wen   = 1'b1;
                bus_addr  = dst_q;
                bus_dat_o = data_q;
                src_d     = src_q + STRIDE;
                dst_d     = dst_q + STRIDE;
                cnt_d     = cnt_q - ONE;
                if (abort) begin
                    state_d = DMA_IDLE;
                end else if (cnt_q == ONE) begin
                    state_d = DMA_FIN;
                end else begin
`ifdef UIB_DMA_FILL_EN
                    state_d = fill_q ? DMA_WR : DMA_RD;
`else
                    state_d = DMA_RD;
`endif
                end
            end
            DMA_FIN: begin
                state_d = DMA_IDLE;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // done is registered one cycle behind FIN so it lands 3N+1 cycles after start.
    assign done_d   = (state_q == DMA_FIN);
    assign done     = done_q;
    assign busy     = (state_q != DMA_IDLE);
    assign bus_mode = UIB_MODE_WORD;

endmodule

// File: tb/tb_uib_dma.sv
// Self-checking bench for uib_dma: table-driven transfers plus abort/reset sequences.
module tb_uib_dma;
    import uib_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
`ifdef UIB_DMA_FILL_EN
    logic        fill;
    logic [31:0] fill_pattern;
`endif
    logic        busy, done, bus_req, bus_wen;
    logic [31:0] bus_addr, bus_dat_o;
    logic [31:0] bus_dat_i = '0;
    logic [1:0]  bus_mode;

    uib_dma #(.XLEN(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .abort(abort),
`ifdef UIB_DMA_FILL_EN
        .fill(fill), .fill_pattern(fill_pattern),
`endif
        .busy(busy), .done(done), .bus_req(bus_req), .bus_wen(bus_wen),
        .bus_addr(bus_addr), .bus_mode(bus_mode), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] dat;
    } ev_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        fill;
        logic [31:0] pat;
        logic        restart;
        logic        abort_st;
        int          exp_lat;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    ev_t ev_q[$];
    int  done_q[$];
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave: read data one cycle after a read request, zero otherwise.
    always @(posedge clk) bus_dat_i <= (bus_req && !bus_wen) ? rd(bus_addr) : 32'h0;

    always @(negedge clk) begin
        if (bus_req) ev_q.push_back('{cyc, bus_wen, bus_addr, bus_dat_o});
        if (done) done_q.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, {31'b0, busy}, 32'h0);
        chk({tag, " done"}, {31'b0, done}, 32'h0);
        chk({tag, " bus_req"}, {31'b0, bus_req}, 32'h0);
        chk({tag, " bus_wen"}, {31'b0, bus_wen}, 32'h0);
        chk({tag, " bus_addr"}, bus_addr, 32'h0);
        chk({tag, " bus_dat_o"}, bus_dat_o, 32'h0);
        chk({tag, " bus_mode"}, {30'b0, bus_mode}, {30'b0, UIB_MODE_WORD});
    endtask

    // Launch a transfer; returns the cycle index of the start edge.
    task automatic launch(input vec_t v, output int s);
        ev_q.delete();
        done_q.delete();
        @(negedge clk);
        src_addr = v.src;
        dst_addr = v.dst;
        len      = v.len;
        abort    = v.abort_st;
`ifdef UIB_DMA_FILL_EN
        fill         = v.fill;
        fill_pattern = v.pat;
`endif
        start = 1'b1;
        s     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run(input vec_t v, input string name);
        int   s;
        ev_t  exp_q[$];
        int   n;
        launch(v, s);
        chk({name, " busy after start"}, {31'b0, busy}, 32'h1);
        if (v.restart) begin
            src_addr = 32'hABC0_0000;
            dst_addr = 32'hDEF0_0000;
            len      = 16'd7;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 300 && done_q.size() == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);

        for (int i = 0; i < int'(v.len); i++) begin
            logic [31:0] sa, da;
            sa = v.src + 32'(4 * i);
            da = v.dst + 32'(4 * i);
            if (v.fill) begin
                exp_q.push_back('{s + i, 1'b1, da, v.pat});
            end else begin
                exp_q.push_back('{s + 3 * i, 1'b0, sa, 32'h0});
                exp_q.push_back('{s + 3 * i + 2, 1'b1, da, rd(sa)});
            end
        end

        chk({name, " done count"}, 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) chk({name, " done latency"}, 32'(done_q[0] - s), 32'(v.exp_lat));
        chk({name, " bus events"}, 32'(ev_q.size()), 32'(exp_q.size()));
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s ev%0d cycle", name, i), 32'(ev_q[i].cyc - s), 32'(exp_q[i].cyc - s));
            chk($sformatf("%s ev%0d wen", name, i), {31'b0, ev_q[i].wen}, {31'b0, exp_q[i].wen});
            chk($sformatf("%s ev%0d addr", name, i), ev_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s ev%0d data", name, i), ev_q[i].dat, exp_q[i].dat);
        end
        chk({name, " idle busy"}, {31'b0, busy}, 32'h0);
    endtask

    function automatic int model_lat(input vec_t v);
        if (v.len == 0) return 1;
        if (v.fill) return int'(v.len) + 1;
        return 3 * int'(v.len) + 1;
    endfunction

    initial begin
        #500000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   s;
        int   nwr;
        int   late;

        mem[32'h100] = 32'h11;
        mem[32'h104] = 32'h22;
        mem[32'h108] = 32'h33;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
`ifdef UIB_DMA_FILL_EN
        fill = 1'b0; fill_pattern = '0;
`endif
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Fixed vectors with spec-given latencies, then random ones.
        vecs.push_back('{32'h100, 32'h200, 16'd3, 1'b0, 32'h0, 1'b0, 1'b0, 10});
        vecs.push_back('{32'h100, 32'h200, 16'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1});
        vecs.push_back('{32'hFFFF_FFFC, 32'h500, 16'd2, 1'b0, 32'h0, 1'b0, 1'b0, 7});
        vecs.push_back('{32'h800, 32'h900, 16'd1, 1'b0, 32'h0, 1'b0, 1'b1, 4});
        vecs.push_back('{32'hA00, 32'hB00, 16'd2, 1'b0, 32'h0, 1'b1, 1'b0, 7});
        vecs.push_back('{32'hC00, 32'hD00, 16'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1});
`ifdef UIB_DMA_FILL_EN
        vecs.push_back('{32'h0, 32'h40, 16'd4, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 5});
        vecs.push_back('{32'h0, 32'hFFFF_FFF8, 16'd3, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 4});
`endif
        for (int i = 0; i < 8; i++) begin
            v.src      = $urandom & 32'hFFFF_FFFC;
            v.dst      = $urandom & 32'hFFFF_FFFC;
            v.len      = 16'($urandom_range(1, 5));
            v.fill     = 1'b0;
`ifdef UIB_DMA_FILL_EN
            v.fill     = 1'($urandom_range(0, 1));
`endif
            v.pat      = $urandom;
            v.restart  = 1'($urandom_range(0, 1));
            v.abort_st = 1'($urandom_range(0, 1));
            v.exp_lat  = model_lat(v);
            vecs.push_back(v);
        end
        foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

        // Abort during the capture of word 2 of a 4-word copy.
        v = '{32'h300, 32'h400, 16'd4, 1'b0, 32'h0, 1'b0, 1'b0, 13};
        launch(v, s);
        while (cyc < s + 4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy falls", {31'b0, busy}, 32'h0);
        repeat (20) @(negedge clk);
        nwr  = 0;
        late = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i].wen) nwr++;
            if (ev_q[i].cyc >= s + 5) late++;
        end
        chk("abort writes", 32'(nwr), 32'd1);
        chk("abort no late req", 32'(late), 32'd0);
        chk("abort no done", 32'(done_q.size()), 32'd0);

        // Reset asserted while the first write is on the bus.
        v = '{32'h600, 32'h700, 16'd3, 1'b0, 32'h0, 1'b0, 1'b0, 10};
        launch(v, s);
        while (cyc < s + 2) @(negedge clk);
        chk("pre-reset in write", {31'b0, bus_wen}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("midrst");
        repeat (10) @(negedge clk);
        chk("midrst no done", 32'(done_q.size()), 32'd0);
        run('{32'h100, 32'h280, 16'd3, 1'b0, 32'h0, 1'b0, 1'b0, 10}, "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
